// File: rtl/l1d_sram_req_ctrl.sv
// Request controller for one single-port registered-input SRAM: reads, full writes,
// byte-masked writes done as read-modify-write, and a small response FIFO.
// Optional: define L1D_SRAM_REQ_WRITE_ACK_EN to return an ack entry (resp_is_wr=1) for every write.
module l1d_sram_req_ctrl #(
  parameter  int WIDTH      = 32,
  parameter  int DEPTH      = 16,
  parameter  int RESP_DEPTH = 2,
  localparam int AW         = $clog2(DEPTH),
  localparam int BW         = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [BW-1:0]    req_wmask,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
`ifdef L1D_SRAM_REQ_WRITE_ACK_EN
  output logic             resp_is_wr,
`endif
  output logic             ram_we,
  output logic [AW-1:0]    ram_a,
  output logic [WIDTH-1:0] ram_d,
  input  logic [WIDTH-1:0] ram_q
);

  localparam int CW    = $clog2(RESP_DEPTH + 1);
  localparam int SLOTS = 1 << CW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    MRG  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    mrg_addr_q;
  logic [WIDTH-1:0] mrg_wdata_q;
  logic [BW-1:0]    mrg_mask_q;
  logic [WIDTH-1:0] fifo_data_q [SLOTS];
`ifdef L1D_SRAM_REQ_WRITE_ACK_EN
  logic             fifo_wr_q   [SLOTS];
`endif

  logic [CW:0]      occ;
  logic             accept;
  logic             wr_full;
  logic             wr_zero;
  logic             acc_rd;
  logic             acc_fw;
  logic             acc_pw;
  logic             acc_zw;
  logic             push_rd;
  logic             push_wa;
  logic             pop;
  logic [CW+1:0]    cnt_sum;
  logic [CW-1:0]    wr_idx;

  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_w,
                                                   input logic [WIDTH-1:0] new_w,
                                                   input logic [BW-1:0]    mask);
    logic [WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < BW; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // A read in RD still owns a FIFO slot; pops in the same cycle are not credited.
  always_comb begin
    occ       = {1'b0, cnt_q} + {{CW{1'b0}}, (state_q == RD)};
    req_ready = !rst && (state_q != MRG) && (occ < (CW+1)'(RESP_DEPTH));
    accept    = req_valid && req_ready;
    wr_full   = &req_wmask;
    wr_zero   = ~|req_wmask;
    acc_rd    = accept && !req_we;
    acc_fw    = accept && req_we && wr_full;
    acc_zw    = accept && req_we && wr_zero && !wr_full;
    acc_pw    = accept && req_we && !wr_full && !wr_zero;
  end

  always_comb begin
    ram_we = 1'b0;
    ram_a  = '0;
    ram_d  = '0;
    if (!rst) begin
      if (state_q == MRG) begin
        ram_we = 1'b1;
        ram_a  = mrg_addr_q;
        ram_d  = merge_bytes(ram_q, mrg_wdata_q, mrg_mask_q);
      end else if (acc_rd || acc_pw) begin
        ram_a  = req_addr;
      end else if (acc_fw) begin
        ram_we = 1'b1;
        ram_a  = req_addr;
        ram_d  = req_wdata;
      end
    end
  end

  always_comb begin
    push_rd = (state_q == RD);
`ifdef L1D_SRAM_REQ_WRITE_ACK_EN
    push_wa = acc_fw || acc_zw || (state_q == MRG);
`else
    push_wa = 1'b0;
`endif
    pop     = resp_valid && resp_ready;
    cnt_sum = (CW+2)'(cnt_q) + (CW+2)'(push_rd) + (CW+2)'(push_wa) - (CW+2)'(pop);
    wr_idx  = cnt_q - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      if (acc_rd)      state_q <= RD;
      else if (acc_pw) state_q <= MRG;
      else             state_q <= IDLE;
      cnt_q <= cnt_sum[CW-1:0];
      assert (cnt_sum <= (CW+2)'(RESP_DEPTH));
    end
  end

  // Shift-style FIFO: head is always slot 0, so up to two pushes land behind the survivors.
  always_ff @(posedge clk) begin
    if (acc_pw) begin
      mrg_addr_q  <= req_addr;
      mrg_wdata_q <= req_wdata;
      mrg_mask_q  <= req_wmask;
    end
    for (int i = 0; i < SLOTS - 1; i++) begin
      if (pop) fifo_data_q[i] <= fifo_data_q[i+1];
    end
    if (push_rd) fifo_data_q[wr_idx] <= ram_q;
`ifdef L1D_SRAM_REQ_WRITE_ACK_EN
    for (int i = 0; i < SLOTS - 1; i++) begin
      if (pop) fifo_wr_q[i] <= fifo_wr_q[i+1];
    end
    if (push_rd) fifo_wr_q[wr_idx] <= 1'b0;
    if (push_wa) begin
      fifo_data_q[wr_idx + CW'(push_rd)] <= '0;
      fifo_wr_q[wr_idx + CW'(push_rd)]   <= 1'b1;
    end
`endif
  end

  assign resp_valid = (cnt_q != '0);
  assign resp_rdata = fifo_data_q[0];
`ifdef L1D_SRAM_REQ_WRITE_ACK_EN
  assign resp_is_wr = fifo_wr_q[0];
`endif

endmodule
